// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports A and B plus the single memory port of mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              a_valid, a_ready, a_we, a_rsp_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rsp_rdata;
  logic              b_valid, b_ready, b_we, b_rsp_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_write, busy;
  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata, mem_read_data,
    output a_ready, a_rsp_valid, a_rsp_rdata, b_ready, b_rsp_valid, b_rsp_rdata,
           mem_address, mem_write_data, mem_write, busy
  );
  modport master (
    output a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata, mem_read_data,
    input  a_ready, a_rsp_valid, a_rsp_rdata, b_ready, b_rsp_valid, b_rsp_rdata,
           mem_address, mem_write_data, mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serializing two request ports onto one synchronous single-port memory.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t            state, state_nx;
  logic              last_b, port_q, we_q, gnt_b, a_acc, b_acc, rd_rsp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, a_rd_q, b_rd_q;
  // B wins only when A is idle or A was served last; rst keeps both ready low
  assign gnt_b  = bus.b_valid & (~bus.a_valid | ~last_b);
  assign a_acc  = (state == IDLE) & ~rst & bus.a_valid & ~gnt_b;
  assign b_acc  = (state == IDLE) & ~rst & gnt_b;
  assign rd_rsp = (state == RESP) & ~we_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((a_acc | b_acc) ? ISSUE : IDLE) : (state == ISSUE) ? RESP : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_b  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
    end else begin
      if (a_acc | b_acc) begin
        last_b  <= b_acc;
        port_q  <= b_acc;
        we_q    <= b_acc ? bus.b_we : bus.a_we;
        addr_q  <= b_acc ? bus.b_addr : bus.a_addr;
        wdata_q <= b_acc ? bus.b_wdata : bus.a_wdata;
      end
      if (rd_rsp && !port_q) a_rd_q <= bus.mem_read_data;
      if (rd_rsp && port_q) b_rd_q <= bus.mem_read_data;
    end
  // read data passes through during RESP, then the captured copy holds it
  always_comb begin
    bus.a_ready        = a_acc;
    bus.b_ready        = b_acc;
    bus.busy           = state != IDLE;
    bus.mem_write      = (state == ISSUE) & we_q;
    bus.mem_address    = addr_q;
    bus.mem_write_data = wdata_q;
    bus.a_rsp_valid    = (state == RESP) & ~port_q;
    bus.b_rsp_valid    = (state == RESP) & port_q;
    bus.a_rsp_rdata    = (rd_rsp && !port_q) ? bus.mem_read_data : a_rd_q;
    bus.b_rsp_rdata    = (rd_rsp && port_q) ? bus.mem_read_data : b_rd_q;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width SHALL be this value.
REQ-002 Parameter DATA_W, default 32, data word width SHALL be this value.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_valid  input  1  port A request valid.
REQ-006 a_ready  output  1  port A request accepted this cycle.
REQ-007 a_we  input  1  port A request type: 1 write, 0 read.
REQ-008 a_addr  input  ADDR_W  port A word address.
REQ-009 a_wdata  input  DATA_W  port A write data.
REQ-010 a_rsp_valid  output  1  port A response pulse: read data or write ack.
REQ-011 a_rsp_rdata  output  DATA_W  port A read data, valid with a_rsp_valid on reads.
REQ-012 b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_rdata SHALL mirror REQ-005..011 for port B.
REQ-013 mem_address  output  ADDR_W  memory address.
REQ-014 mem_write_data  output  DATA_W  memory write data.
REQ-015 mem_write  output  1  memory write enable; memory reads when low.
REQ-016 mem_read_data  input  DATA_W  memory registered read data, valid one edge after address is presented with mem_write=0.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on accept, ISSUE->RESP always, and RESP->IDLE always.
REQ-019 In IDLE, exactly one x_ready SHALL be high, combinationally, for the granted port when its x_valid is high; both ready SHALL be low in ISSUE and RESP.
REQ-020 Grant SHALL be round-robin: with one valid the grant goes to that port; with both valid it goes to the port not granted last; last_grant updates only on accept.
REQ-021 On accept (x_valid & x_ready at the edge), the block SHALL latch we, addr, wdata and the port id into internal registers.
REQ-022 In ISSUE, mem_address and mem_write_data SHALL come from the latched values, and mem_write SHALL equal the latched we.
REQ-023 mem_write SHALL be 0 in IDLE and RESP; mem_address and mem_write_data SHALL hold their last values outside ISSUE.
REQ-024 In RESP, only the latched port's x_rsp_valid SHALL be high, for exactly one cycle.
REQ-025 For reads, x_rsp_rdata SHALL equal mem_read_data during RESP and SHALL hold that value until the next read response on that port.
REQ-026 For writes, x_rsp_valid SHALL act as the write ack and x_rsp_rdata SHALL be unchanged.
REQ-027 Latency SHALL be fixed: accept at edge N, ISSUE in cycle N+1, RESP in cycle N+2, IDLE in cycle N+3; maximum throughput is one transaction per 3 cycles.
REQ-028 A request held valid while not granted SHALL remain pending with no side effect; the block does not require requesters to keep x_valid stable.
REQ-029 A write followed by a read to the same address, from either port, SHALL return the written data, because accesses are strictly serialized.
REQ-030 Address values SHALL pass through unmodified, and the full 0..2^ADDR_W-1 range SHALL be legal.

Reset
REQ-031 While rst is high, the block SHALL hold: state IDLE, last_grant=B (so A wins the first tie), mem_write=0, mem_address=0, mem_write_data=0, both rsp_valid=0, both rsp_rdata=0, busy=0, and both ready=0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately: mem_write drops asynchronously, and no response SHALL be issued after reset is released.

Verification
REQ-033 Reset release, a_valid=1, a_we=1, a_addr=0x005, a_wdata=0xDEADBEEF -> a_ready=1 in cycle 0, mem_write=1 and mem_address=0x005 in cycle 1, a_rsp_valid=1 in cycle 2.
REQ-034 Following REQ-033, b reads 0x005 -> b_rsp_valid=1 with b_rsp_rdata=0xDEADBEEF exactly 2 cycles after accept, and a_rsp_valid stays 0.
REQ-035 a_valid and b_valid held high continuously after reset -> grants alternate A,B,A,B; each accept is 3 cycles apart; busy drops only for the IDLE cycles.
REQ-036 Write 0x3FF=0x12345678, then read 0x3FF -> 0x12345678; read 0x000 after reset with no write -> response issued with no X on control signals.
REQ-037 rst asserted during ISSUE of a write -> mem_write=0 within the same cycle, no rsp_valid after release, and the next request is granted to A.
